// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_gen
//  Purpose  : Free-running VGA raster timing generator. A clock divider
//             produces a pixel-rate strobe; horizontal and vertical counters
//             walk the raster, and sync/blanking are decoded directly from
//             the counter registers. A frame strobe and a frame counter are
//             provided for slow-rate consumers such as sprite controllers.
//  Ports    : clk         - system clock, all state on rising edge
//             rst         - asynchronous active-high reset
//             hCount[9:0] - horizontal pixel position, 0..H_TOTAL-1
//             vCount[9:0] - vertical line position, 0..V_TOTAL-1
//             hSync       - horizontal sync, active-low (hCount 0..95)
//             vSync       - vertical sync, active-low (vCount 0..1)
//             bright      - high inside the 640x480 visible window
//             pix_tick    - one-clk strobe on each pixel advance
//             frame_tick  - one-clk strobe at the frame wrap
//             frame_count - frames completed since reset, modulo 256
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_gen #(
    parameter int CLK_DIV = 4,
    parameter int H_TOTAL = 800,
    parameter int V_TOTAL = 525
) (
    input  logic       clk,
    input  logic       rst,
    output logic [9:0] hCount,
    output logic [9:0] vCount,
    output logic       hSync,
    output logic       vSync,
    output logic       bright,
    output logic       pix_tick,
    output logic       frame_tick,
    output logic [7:0] frame_count
);

    // A one-clock-per-pixel configuration still needs a 1-bit divider
    // register; it simply stays at zero so pix_tick is permanently high.
    localparam int         DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);

    // Fixed 640x480 timing windows
    localparam logic [9:0] HS_END      = 10'd96;   // hSync low for 0..95
    localparam logic [9:0] VS_END      = 10'd2;    // vSync low for 0..1
    localparam logic [9:0] H_VIS_FIRST = 10'd144;
    localparam logic [9:0] H_VIS_LAST  = 10'd783;
    localparam logic [9:0] V_VIS_FIRST = 10'd35;
    localparam logic [9:0] V_VIS_LAST  = 10'd514;

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d;
    logic [9:0]       v_q, v_d;
    logic [7:0]       frame_q, frame_d;

    logic             h_last;
    logic             v_last;

    assign h_last     = (h_q == H_LAST);
    assign v_last     = (v_q == V_LAST);
    assign pix_tick   = (div_q == DIV_LAST);
    assign frame_tick = pix_tick && h_last && v_last;

    always_comb begin
        div_d   = div_q;
        h_d     = h_q;
        v_d     = v_q;
        frame_d = frame_q;

        if (div_q == DIV_LAST) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end

        if (pix_tick) begin
            if (h_last) begin
                h_d = '0;
                // Vertical advances only on the horizontal wrap
                if (v_last) begin
                    v_d = '0;
                end else begin
                    v_d = v_q + 10'd1;
                end
            end else begin
                h_d = h_q + 10'd1;
            end
        end

        if (frame_tick) begin
            frame_d = frame_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
        end
    end

    // Zero-latency decode straight from the counter registers
    assign hCount      = h_q;
    assign vCount      = v_q;
    assign frame_count = frame_q;
    assign hSync       = (h_q >= HS_END);
    assign vSync       = (v_q >= VS_END);
    assign bright      = (h_q >= H_VIS_FIRST) && (h_q <= H_VIS_LAST) &&
                         (v_q >= V_VIS_FIRST) && (v_q <= V_VIS_LAST);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_gen
//  Purpose  : Self-checking bench for vga_timing_gen. A reduced raster on
//             the main instance keeps frames short while still crossing the
//             sync and visible-window boundaries; a tiny second instance
//             covers the 256-frame counter wrap.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_gen;

    localparam int D1 = 4;
    localparam int H1 = 146;
    localparam int V1 = 37;
    localparam int D2 = 1;
    localparam int H2 = 8;
    localparam int V2 = 4;
    localparam int BOUND = 30000;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst2 = 1'b1;

    always #5 clk = ~clk;

    logic [9:0] hc1, vc1, hc2, vc2;
    logic       hs1, vs1, br1, pt1, ft1;
    logic       hs2, vs2, br2, pt2, ft2;
    logic [7:0] fc1, fc2;

    vga_timing_gen #(.CLK_DIV(D1), .H_TOTAL(H1), .V_TOTAL(V1)) u_dut (
        .clk(clk), .rst(rst), .hCount(hc1), .vCount(vc1), .hSync(hs1),
        .vSync(vs1), .bright(br1), .pix_tick(pt1), .frame_tick(ft1),
        .frame_count(fc1)
    );

    vga_timing_gen #(.CLK_DIV(D2), .H_TOTAL(H2), .V_TOTAL(V2)) u_small (
        .clk(clk), .rst(rst2), .hCount(hc2), .vCount(vc2), .hSync(hs2),
        .vSync(vs2), .bright(br2), .pix_tick(pt2), .frame_tick(ft2),
        .frame_count(fc2)
    );

    // ------------------------------------------------------------------
    // Reference model: everything follows from the number of clock edges
    // since reset was released.
    // ------------------------------------------------------------------
    int n1 = 0;
    int n2 = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) n1 <= 0;
        else     n1 <= n1 + 1;
    end

    always @(posedge clk or posedge rst2) begin
        if (rst2) n2 <= 0;
        else      n2 <= n2 + 1;
    end

    function automatic logic [30:0] model(input int n, input int d,
                                          input int ht, input int vt);
        int p, h, v, f;
        logic pt, hs, vs, br, ft;
        p  = n / d;
        h  = p % ht;
        v  = (p / ht) % vt;
        f  = (p / (ht * vt)) % 256;
        pt = (n % d) == (d - 1);
        hs = (h >= 96);
        vs = (v >= 2);
        br = (h >= 144) && (h <= 783) && (v >= 35) && (v <= 514);
        ft = pt && (h == ht - 1) && (v == vt - 1);
        return {10'(h), 10'(v), hs, vs, br, pt, ft, 8'(f)};
    endfunction

    // Per-cycle compare plus statistics gathered on the falling edge
    int chk_cmp  = 0;
    int fail_cmp = 0;
    int pt_total = 0, hs_low = 0, vs_low = 0, br_total = 0;
    int ft_total = 0, ft2_total = 0;

    always @(negedge clk) begin
        logic [30:0] exp1, exp2, act1, act2;
        exp1 = model(n1, D1, H1, V1);
        exp2 = model(n2, D2, H2, V2);
        act1 = {hc1, vc1, hs1, vs1, br1, pt1, ft1, fc1};
        act2 = {hc2, vc2, hs2, vs2, br2, pt2, ft2, fc2};
        chk_cmp = chk_cmp + 2;
        if (act1 !== exp1) begin
            fail_cmp = fail_cmp + 1;
            if (fail_cmp <= 20)
                $display("FAIL model_main t=%0t got=%h expected=%h", $time, act1, exp1);
        end
        if (act2 !== exp2) begin
            fail_cmp = fail_cmp + 1;
            if (fail_cmp <= 20)
                $display("FAIL model_small t=%0t got=%h expected=%h", $time, act2, exp2);
        end
        if (pt1) begin
            pt_total = pt_total + 1;
            if (!hs1) hs_low   = hs_low + 1;
            if (!vs1) vs_low   = vs_low + 1;
            if (br1)  br_total = br_total + 1;
        end
        if (ft1) ft_total  = ft_total + 1;
        if (ft2) ft2_total = ft2_total + 1;
    end

    // ------------------------------------------------------------------
    // Directed checks with hand-computed expectations
    // ------------------------------------------------------------------
    int chk_main  = 0;
    int fail_main = 0;

    task automatic check(input string name, input int act, input int exp);
        chk_main = chk_main + 1;
        if (act != exp) begin
            fail_main = fail_main + 1;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_pix(input int target);
        int g = 0;
        while (pt_total < target && g < BOUND) begin step(); g++; end
        if (g >= BOUND) check("timeout_pix", pt_total, target);
    endtask

    task automatic wait_pos(input int h, input int v);
        int g = 0;
        while (!(int'(hc1) == h && int'(vc1) == v) && g < 4 * BOUND) begin step(); g++; end
        if (g >= 4 * BOUND) check("timeout_pos", int'(hc1) * 1024 + int'(vc1), h * 1024 + v);
    endtask

    task automatic wait_ft(input int target);
        int g = 0;
        while (ft_total < target && g < 4 * BOUND) begin step(); g++; end
        if (g >= 4 * BOUND) check("timeout_ft", ft_total, target);
    endtask

    initial begin
        logic [7:0] pt_bits;
        int ft_before, pt_snap, g;

        repeat (3) @(negedge clk);
        check("rst_hCount",   int'(hc1), 0);
        check("rst_vCount",   int'(vc1), 0);
        check("rst_hSync",    int'(hs1), 0);
        check("rst_vSync",    int'(vs1), 0);
        check("rst_bright",   int'(br1), 0);
        check("rst_pix_tick", int'(pt1), 0);
        check("rst_frame_tk", int'(ft1), 0);
        check("rst_frame_ct", int'(fc1), 0);

        rst  = 1'b0;
        rst2 = 1'b0;
        // Divider: pix_tick in clock periods 4 and 8 only, hCount ends at 2
        for (int k = 0; k < 8; k++) begin
            pt_bits[k] = pt1;
            step();
        end
        check("div_pattern", int'(pt_bits), 8'b1000_1000);
        check("div_hCount",  int'(hc1), 2);

        // One full line
        wait_pix(H1);
        check("line_hCount",  int'(hc1), 0);
        check("line_vCount",  int'(vc1), 1);
        check("line_hs_low",  hs_low, 96);

        // 256 frames of the small instance wrap its frame counter
        g = 0;
        while (ft2_total < 256 && g < BOUND) begin step(); g++; end
        check("wrap_ticks", ft2_total, 256);
        check("wrap_count", int'(fc2), 0);

        // One full frame of the main instance
        wait_pix(H1 * V1);
        check("frame_hCount", int'(hc1), 0);
        check("frame_vCount", int'(vc1), 0);
        check("frame_ticks",  ft_total, 1);
        check("frame_count",  int'(fc1), 1);
        check("frame_vs_low", vs_low, 292);
        check("frame_hs_low", hs_low, 3552);
        check("frame_bright", br_total, 4);

        // Visible-window corners
        wait_pos(144, 34);  check("win_144_34", int'(br1), 0);
        wait_pos(143, 35);  check("win_143_35", int'(br1), 0);
        wait_pos(144, 35);  check("win_144_35", int'(br1), 1);
        wait_pos(145, 36);  check("win_145_36", int'(br1), 1);

        // Mid-frame asynchronous reset
        wait_pos(100, 20);
        #2;
        rst = 1'b1;
        #1;
        check("mrst_hCount",   int'(hc1), 0);
        check("mrst_vCount",   int'(vc1), 0);
        check("mrst_pix_tick", int'(pt1), 0);
        check("mrst_frame_ct", int'(fc1), 0);
        ft_before = ft_total;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        pt_snap = pt_total;
        wait_ft(ft_before + 1);
        check("mrst_frame_len", pt_total - pt_snap, H1 * V1);
        check("mrst_ticks",     ft_total - ft_before, 1);
        check("mrst_frame_ct2", int'(fc1), 1);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d",
                 chk_main + chk_cmp, fail_main + fail_cmp);
        $finish;
    end

endmodule
`default_nettype wire
